// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame receiver.
//   state_t    : receiver FSM states
//   FRAME_BITS : default frame length in bits
//   RW_BIT, ADDR_MSB/LSB, DATA_MSB/LSB : field positions in a default-sized frame,
//                also used by the control-register bank that consumes the frames
package spi_frame_pkg;

   localparam int FRAME_BITS = 16;

   localparam int RW_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   typedef enum logic [1:0] {
      WAIT_HIGH,
      IDLE,
      SHIFT
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Pin synchronizer with edge detection.
//   clk, rst   : system clock, synchronous active-high reset
//   pin        : raw asynchronous input
//   level      : synchronized level (last chain stage)
//   rise, fall : one-cycle edge indications, derived from level and its history
// STAGES flops form the chain; RESET_VAL is loaded into every chain stage and
// into the history register so that the idle level of the pin shows no edge.
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], pin};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = chain[STAGES-1] & ~prev;
   assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0, MSB-first frame receiver running entirely in the clk domain.
//   clk, rst       : system clock, synchronous active-high reset
//   sclk_i, copi_i, ncs_i : raw SPI pins (asynchronous)
//   frame_valid_o  : one-cycle pulse when a FRAME_BITS-long frame completes
//   frame_write_o  : frame MSB (1 = write)
//   frame_addr_o   : address field
//   frame_data_o   : data field
//   frame_error_o  : one-cycle pulse when a frame ends with a wrong bit count
//   busy_o         : high while a frame is being shifted in
// Field outputs hold the last valid frame until the next one or reset.
module spi_frame_receiver
   import spi_frame_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = spi_frame_pkg::FRAME_BITS,
   parameter int ADDR_BITS   = 7,
   parameter int DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sclk_i,
   input  logic                 copi_i,
   input  logic                 ncs_i,
   output logic                 frame_valid_o,
   output logic                 frame_write_o,
   output logic [ADDR_BITS-1:0] frame_addr_o,
   output logic [DATA_BITS-1:0] frame_data_o,
   output logic                 frame_error_o,
   output logic                 busy_o
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(SYNC_STAGES);

   logic sclk_level, sclk_rise, sclk_fall_unused;
   logic copi_level, copi_rise_unused, copi_fall_unused;
   logic ncs_level, ncs_rise, ncs_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .pin(sclk_i),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
      .clk(clk), .rst(rst), .pin(copi_i),
      .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
      .clk(clk), .rst(rst), .pin(ncs_i),
      .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
   );

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  valid_d, error_d, write_d;
   logic [ADDR_BITS-1:0]  addr_d;
   logic [DATA_BITS-1:0]  data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_HIGH;
         shift_q       <= '0;
         count_q       <= '0;
         frame_valid_o <= 1'b0;
         frame_error_o <= 1'b0;
         frame_write_o <= 1'b0;
         frame_addr_o  <= '0;
         frame_data_o  <= '0;
         busy_o        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         count_q       <= count_d;
         frame_valid_o <= valid_d;
         frame_error_o <= error_d;
         frame_write_o <= write_d;
         frame_addr_o  <= addr_d;
         frame_data_o  <= data_d;
         busy_o        <= (state_d == SHIFT);
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      write_d = frame_write_o;
      addr_d  = frame_addr_o;
      data_d  = frame_data_o;
      case (state_q)
         // The nCS chain comes out of reset holding 1s. Waiting SYNC_STAGES
         // cycles flushes it, so the high level seen here is the real pin and
         // a frame already in flight at reset release cannot look like a fresh
         // falling edge.
         WAIT_HIGH: begin
            if (count_q != CNT_FLUSH) begin
               count_d = count_q + 1'b1;
            end else if (ncs_level) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         IDLE: begin
            if (ncs_fall) begin
               state_d = SHIFT;
               shift_d = '0;
               count_d = '0;
            end
         end
         SHIFT: begin
            // nCS rise takes priority: an SCLK rise in the same cycle is dropped.
            if (ncs_rise) begin
               state_d = IDLE;
               if (count_q == CNT_FULL) begin
                  valid_d = 1'b1;
                  write_d = shift_q[FRAME_BITS-1];
                  addr_d  = shift_q[FRAME_BITS-2 -: ADDR_BITS];
                  data_d  = shift_q[DATA_BITS-1:0];
               end else begin
                  error_d = 1'b1;
               end
            end else if (sclk_rise && !ncs_level) begin
               shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
               if (count_q != CNT_SAT) begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = WAIT_HIGH;
      endcase
   end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomized bench for spi_frame_receiver. Two instances (2 and 3 synchronizer
// stages) share the pins; a frame-level model decides from the bit count of
// each transaction whether a valid frame or an error is due.
module tb_spi_frame_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sclk_i, copi_i, ncs_i;

   logic       a_valid, a_write, a_error, a_busy;
   logic [6:0] a_addr;
   logic [7:0] a_data;
   logic       b_valid, b_write, b_error, b_busy;
   logic [6:0] b_addr;
   logic [7:0] b_data;

   spi_frame_receiver #(.SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
      .frame_valid_o(a_valid), .frame_write_o(a_write), .frame_addr_o(a_addr),
      .frame_data_o(a_data), .frame_error_o(a_error), .busy_o(a_busy)
   );

   spi_frame_receiver #(.SYNC_STAGES(3)) dut_b (
      .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
      .frame_valid_o(b_valid), .frame_write_o(b_write), .frame_addr_o(b_addr),
      .frame_data_o(b_data), .frame_error_o(b_error), .busy_o(b_busy)
   );

   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [15:0] exp_q_a[$];
   logic [15:0] exp_q_b[$];
   logic [15:0] last_frame = 16'h0;
   int exp_v = 0;
   int exp_e = 0;
   int a_vcnt = 0, a_ecnt = 0, b_vcnt = 0, b_ecnt = 0;
   logic [15:0] pop_a, pop_b;

   // A transaction that clocked exactly 16 bits yields its 16 bits as a frame.
   task automatic model_end(input logic [31:0] bits, input int counted);
      if (counted == 16) begin
         exp_q_a.push_back(bits[15:0]);
         exp_q_b.push_back(bits[15:0]);
         last_frame = bits[15:0];
         exp_v++;
      end else begin
         exp_e++;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (a_valid) begin
            a_vcnt++;
            if (exp_q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
            else begin
               pop_a = exp_q_a.pop_front();
               check("a_frame", {16'h0, a_write, a_addr, a_data}, {16'h0, pop_a});
            end
         end
         if (b_valid) begin
            b_vcnt++;
            if (exp_q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
            else begin
               pop_b = exp_q_b.pop_front();
               check("b_frame", {16'h0, b_write, b_addr, b_data}, {16'h0, pop_b});
            end
         end
         if (a_error) a_ecnt++;
         if (b_error) b_ecnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b, input int half);
      copi_i = b;
      tick(half);
      sclk_i = 1'b1;
      tick(half);
      sclk_i = 1'b0;
   endtask

   // collide: nCS rises together with the last SCLK rise, so that bit is lost.
   task automatic send_frame(input logic [31:0] bits, input int nbits, input int half,
                             input bit collide, input int gap);
      ncs_i = 1'b0;
      tick(half);
      for (int i = nbits - 1; i >= 0; i--) begin
         if (collide && i == 0) begin
            copi_i = bits[i];
            tick(half);
            model_end(bits, nbits - 1);
            sclk_i = 1'b1;
            ncs_i  = 1'b1;
            tick(half);
            sclk_i = 1'b0;
         end else begin
            shift_bit(bits[i], half);
         end
         if (i == nbits - 3) begin
            check("a_busy_mid", {31'h0, a_busy}, 32'd1);
            check("b_busy_mid", {31'h0, b_busy}, 32'd1);
         end
      end
      if (!collide) begin
         tick(half);
         model_end(bits, nbits);
         ncs_i = 1'b1;
      end
      tick(gap);
   endtask

   task automatic checkpoint(input string tag);
      tick(12);
      check({tag, "_a_valid_cnt"}, a_vcnt, exp_v);
      check({tag, "_b_valid_cnt"}, b_vcnt, exp_v);
      check({tag, "_a_error_cnt"}, a_ecnt, exp_e);
      check({tag, "_b_error_cnt"}, b_ecnt, exp_e);
      check({tag, "_a_fields"}, {16'h0, a_write, a_addr, a_data}, {16'h0, last_frame});
      check({tag, "_b_fields"}, {16'h0, b_write, b_addr, b_data}, {16'h0, last_frame});
      check({tag, "_a_busy_idle"}, {31'h0, a_busy}, 32'd0);
      check({tag, "_b_busy_idle"}, {31'h0, b_busy}, 32'd0);
      check({tag, "_a_queue"}, exp_q_a.size(), 32'd0);
      check({tag, "_b_queue"}, exp_q_b.size(), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat_a, lat_b;
      logic [15:0] rf;
      rst = 1'b1;
      sclk_i = 1'b0;
      copi_i = 1'b0;
      ncs_i = 1'b1;
      tick(3);
      check("rst_a_outputs", {26'h0, a_valid, a_error, a_busy, a_write, |a_addr, |a_data}, 32'd0);
      check("rst_b_outputs", {26'h0, b_valid, b_error, b_busy, b_write, |b_addr, |b_data}, 32'd0);
      rst = 1'b0;
      tick(8);

      // Write frame 0x80F0, with latency measured from the nCS rise.
      ncs_i = 1'b0;
      tick(4);
      rf = 16'h80F0;
      for (int i = 15; i >= 0; i--) begin
         shift_bit(rf[i], 4);
         if (i == 13) check("a_busy_first", {31'h0, a_busy}, 32'd1);
      end
      tick(4);
      model_end({16'h0, rf}, 16);
      ncs_i = 1'b1;
      lat_a = 0;
      lat_b = 0;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (a_valid && lat_a == 0) lat_a = k;
         if (b_valid && lat_b == 0) lat_b = k;
      end
      check("a_latency", lat_a, 32'd3);
      check("b_latency", lat_b, 32'd4);
      checkpoint("write_80f0");

      // Read frame then back-to-back write with 2 clk of nCS high.
      send_frame(32'h0412, 16, 4, 1'b0, 2);
      send_frame(32'h8155, 16, 4, 1'b0, 2);
      checkpoint("back_to_back");

      // Short and long frames.
      send_frame(32'h1234, 15, 4, 1'b0, 6);
      checkpoint("short_15");
      send_frame(32'h1ABCD, 17, 4, 1'b0, 6);
      checkpoint("long_17");

      // nCS rise coincides with the 16th SCLK rise.
      send_frame(32'h8777, 16, 4, 1'b1, 6);
      checkpoint("collide");

      // Reset in the middle of 0x8233 while nCS stays low.
      rf = 16'h8233;
      ncs_i = 1'b0;
      tick(4);
      for (int i = 15; i >= 8; i--) shift_bit(rf[i], 4);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      last_frame = 16'h0;
      check("a_rst_fields", {16'h0, a_write, a_addr, a_data}, 32'd0);
      check("b_rst_fields", {16'h0, b_write, b_addr, b_data}, 32'd0);
      for (int i = 7; i >= 0; i--) shift_bit(rf[i], 4);
      tick(4);
      ncs_i = 1'b1;
      tick(6);
      checkpoint("reset_mid");
      send_frame(32'h8155, 16, 4, 1'b0, 4);
      checkpoint("after_reset");

      // Randomized frames.
      for (int n = 0; n < 24; n++) begin
         int r, nb, half, gap;
         bit col;
         r    = $urandom_range(0, 9);
         nb   = (r < 6) ? 16 : ((r < 8) ? 15 : 17);
         col  = ($urandom_range(0, 7) == 0);
         half = $urandom_range(3, 6);
         gap  = $urandom_range(2, 6);
         send_frame($urandom, nb, half, col, gap);
         checkpoint("random");
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
